// File: rtl/bus_timer.sv
`default_nettype none
// ============================================================================
//  Module   : bus_timer
//  Purpose  : Memory-mapped timer on the data-memory bus. Prescaled 32-bit
//             up-counter with compare register, sticky match flag and a
//             registered level interrupt. Zero-wait-state reads.
//  Revision : 1.0  initial release
// ============================================================================
module bus_timer #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ram_request_i,
    input  logic                  ram_we_i,
    input  logic [ADDR_WIDTH-1:0] ram_addr_i,
    input  logic [DATA_WIDTH-1:0] ram_wdata_i,
    output logic [DATA_WIDTH-1:0] ram_rdata_o,
    output logic                  irq_o
);

    // Word indices within the 256-byte window
    localparam logic [5:0] c_IDX_CTRL     = 6'd0;
    localparam logic [5:0] c_IDX_PRESCALE = 6'd1;
    localparam logic [5:0] c_IDX_COUNT    = 6'd2;
    localparam logic [5:0] c_IDX_COMPARE  = 6'd3;
    localparam logic [5:0] c_IDX_STATUS   = 6'd4;

    localparam logic [DATA_WIDTH-1:0] c_ONE  = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] c_ZERO = '0;

    // CTRL bit positions
    localparam int c_EN = 0;
    localparam int c_AR = 1;
    localparam int c_IE = 2;

    // Architectural state
    logic [2:0]            r_ctrl;
    logic [DATA_WIDTH-1:0] r_prescale;
    logic [DATA_WIDTH-1:0] r_count;
    logic [DATA_WIDTH-1:0] r_compare;
    logic                  r_match;
    logic [DATA_WIDTH-1:0] r_psc;
    logic                  r_irq;

    // Decode and next-state values
    logic                  w_sel;
    logic [5:0]            w_idx;
    logic                  w_wr;
    logic                  w_wr_ctrl;
    logic                  w_wr_prescale;
    logic                  w_wr_count;
    logic                  w_wr_compare;
    logic                  w_wr_status;
    logic                  w_tick;
    logic                  w_hit;
    logic [2:0]            w_ctrl_n;
    logic [DATA_WIDTH-1:0] w_prescale_n;
    logic [DATA_WIDTH-1:0] w_count_n;
    logic [DATA_WIDTH-1:0] w_compare_n;
    logic                  w_match_n;
    logic [DATA_WIDTH-1:0] w_psc_n;
    logic                  w_unused_addr;

    // Byte lane bits are meaningless for full-word-only access
    assign w_unused_addr = ^ram_addr_i[1:0];

    // Address decode and write strobes
    always_comb begin
        w_sel         = ram_request_i && (ram_addr_i[ADDR_WIDTH-1:8] == BASE_ADDR[ADDR_WIDTH-1:8]);
        w_idx         = ram_addr_i[7:2];
        w_wr          = w_sel && ram_we_i;
        w_wr_ctrl     = w_wr && (w_idx == c_IDX_CTRL);
        w_wr_prescale = w_wr && (w_idx == c_IDX_PRESCALE);
        w_wr_count    = w_wr && (w_idx == c_IDX_COUNT);
        w_wr_compare  = w_wr && (w_idx == c_IDX_COMPARE);
        w_wr_status   = w_wr && (w_idx == c_IDX_STATUS);
        // Tick and match use the current (pre-write) register contents
        w_tick        = r_ctrl[c_EN] && (r_psc == r_prescale);
        // A bus write to COUNT discards the tick, so no match is evaluated
        w_hit         = w_tick && !w_wr_count && (r_count == r_compare);
    end

    // Next-state computation for all timer registers
    always_comb begin
        w_ctrl_n     = w_wr_ctrl     ? ram_wdata_i[2:0] : r_ctrl;
        w_prescale_n = w_wr_prescale ? ram_wdata_i      : r_prescale;
        w_compare_n  = w_wr_compare  ? ram_wdata_i      : r_compare;

        // Prescaler: idle when disabled, restarted by a PRESCALE write
        if (!r_ctrl[c_EN] || w_wr_prescale || w_tick) begin
            w_psc_n = c_ZERO;
        end else begin
            w_psc_n = r_psc + c_ONE;
        end

        // Counter: bus write has priority over the tick
        if (w_wr_count) begin
            w_count_n = ram_wdata_i;
        end else if (w_hit && r_ctrl[c_AR]) begin
            w_count_n = c_ZERO;
        end else if (w_tick) begin
            w_count_n = r_count + c_ONE;
        end else begin
            w_count_n = r_count;
        end

        // Sticky match: a new match beats a simultaneous W1C
        if (w_hit) begin
            w_match_n = 1'b1;
        end else if (w_wr_status && ram_wdata_i[0]) begin
            w_match_n = 1'b0;
        end else begin
            w_match_n = r_match;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ctrl     <= 3'b000;
            r_prescale <= c_ZERO;
            r_count    <= c_ZERO;
            r_compare  <= c_ZERO;
            r_match    <= 1'b0;
            r_psc      <= c_ZERO;
            r_irq      <= 1'b0;
        end else begin
            r_ctrl     <= w_ctrl_n;
            r_prescale <= w_prescale_n;
            r_count    <= w_count_n;
            r_compare  <= w_compare_n;
            r_match    <= w_match_n;
            r_psc      <= w_psc_n;
            r_irq      <= w_match_n && w_ctrl_n[c_IE];
        end
    end

    // Zero-latency read mux; unselected or write cycles return 0
    always_comb begin
        ram_rdata_o = c_ZERO;
        if (w_sel && !ram_we_i) begin
            case (w_idx)
                c_IDX_CTRL:     ram_rdata_o = {{(DATA_WIDTH-3){1'b0}}, r_ctrl};
                c_IDX_PRESCALE: ram_rdata_o = r_prescale;
                c_IDX_COUNT:    ram_rdata_o = r_count;
                c_IDX_COMPARE:  ram_rdata_o = r_compare;
                c_IDX_STATUS:   ram_rdata_o = {{(DATA_WIDTH-1){1'b0}}, r_match};
                default:        ram_rdata_o = c_ZERO;
            endcase
        end
    end

    assign irq_o = r_irq;

endmodule
`default_nettype wire
